// File: rtl/ysyx_24080014_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ysyx_24080014_pkg                                               |
// | Purpose  : Shared definitions for the IFU/LSU memory arbiter: FSM state    |
// |            encodings, grant identifiers and the default watchdog limit.    |
// | Ports    : none (package)                                                  |
// | Config   : YSYX_24080014_ARB_RR_EN selects round-robin arbitration         |
// |            (consumed in ysyx_24080014_arb_pick).                           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package ysyx_24080014_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   localparam logic GNT_IFU = 1'b0;
   localparam logic GNT_LSU = 1'b1;

   localparam int TIMEOUT_DEF = 255;

endpackage
`default_nettype wire

// File: rtl/ysyx_24080014_arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ysyx_24080014_arb_pick                                          |
// | Purpose  : Combinational 2-way request picker for the memory arbiter.      |
// | Ports    : ifu_v  in  1  IFU request valid                                 |
// |            lsu_v  in  1  LSU request valid                                 |
// |            ptr    in  1  id of the requester granted last                  |
// |            gnt_v  out 1  some requester is granted                         |
// |            gnt_id out 1  granted requester (GNT_IFU / GNT_LSU)             |
// | Config   : YSYX_24080014_ARB_RR_EN defined  -> round-robin on contention   |
// |            undefined                        -> fixed priority, LSU first   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ysyx_24080014_arb_pick
   import ysyx_24080014_pkg::*;
(
   input  logic ifu_v,
   input  logic lsu_v,
   input  logic ptr,
   output logic gnt_v,
   output logic gnt_id
);

   always_comb begin
      gnt_v  = ifu_v | lsu_v;
      gnt_id = lsu_v ? GNT_LSU : GNT_IFU;
`ifdef YSYX_24080014_ARB_RR_EN
      // On contention favour whoever was not granted last.
      if (ifu_v && lsu_v) begin
         gnt_id = ~ptr;
      end
`else
      // LSU wins so a store always reaches memory before a later fetch.
      if (ptr) begin
         gnt_id = gnt_id;
      end
`endif
   end

endmodule
`default_nettype wire

// File: rtl/ysyx_24080014_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ysyx_24080014_mem_arbiter                                       |
// | Purpose  : Shares one single-port memory access unit between the IFU       |
// |            (read-only) and the LSU (read/write). One transaction at a      |
// |            time: IDLE -> ISSUE (1-cycle command) -> WAIT -> RESP.          |
// |            A watchdog in WAIT returns an error response on expiry.         |
// | Ports    : clk, rst (async, active-high)                                   |
// |            ifu_req_*/ifu_resp_*, ifu_addr, ifu_rdata, ifu_resp_err         |
// |            lsu_req_*/lsu_resp_*, lsu_wen/addr/wdata/wmask, lsu_rdata, err  |
// |            mem_inst_ready/wen/ren/waddr/raddr/din/wmask (to memory)        |
// |            mem_ready/mem_dout (from memory)                                |
// | Config   : YSYX_24080014_ARB_RR_EN -> round-robin instead of LSU priority  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ysyx_24080014_mem_arbiter
   import ysyx_24080014_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = TIMEOUT_DEF
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          ifu_req_valid,
   output logic          ifu_req_ready,
   input  logic [AW-1:0] ifu_addr,
   output logic          ifu_resp_valid,
   input  logic          ifu_resp_ready,
   output logic [DW-1:0] ifu_rdata,
   output logic          ifu_resp_err,
   input  logic          lsu_req_valid,
   output logic          lsu_req_ready,
   input  logic          lsu_wen,
   input  logic [AW-1:0] lsu_addr,
   input  logic [DW-1:0] lsu_wdata,
   input  logic [7:0]    lsu_wmask,
   output logic          lsu_resp_valid,
   input  logic          lsu_resp_ready,
   output logic [DW-1:0] lsu_rdata,
   output logic          lsu_resp_err,
   output logic          mem_inst_ready,
   output logic          mem_wen,
   output logic          mem_ren,
   output logic [AW-1:0] mem_waddr,
   output logic [AW-1:0] mem_raddr,
   output logic [DW-1:0] mem_din,
   output logic [7:0]    mem_wmask,
   input  logic          mem_ready,
   input  logic [DW-1:0] mem_dout
);

   localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

   state_e        state_q, state_d;
   logic          gnt_q, gnt_d;
   logic          ptr_q, ptr_d;
   logic          wen_q, wen_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [7:0]    wmask_q, wmask_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          err_q, err_d;
   logic          cmd_q, cmd_d;
   logic          mwen_q, mwen_d;
   logic          mren_q, mren_d;
   logic          ifu_rv_q, ifu_rv_d;
   logic          lsu_rv_q, lsu_rv_d;

   logic          pick_v;
   logic          pick_id;
   logic          hs;

   ysyx_24080014_arb_pick u_pick (
      .ifu_v  (ifu_req_valid),
      .lsu_v  (lsu_req_valid),
      .ptr    (ptr_q),
      .gnt_v  (pick_v),
      .gnt_id (pick_id)
   );

   assign hs = (state_q == IDLE) && pick_v;

   // Ready is gated by rst so every output reads 0 while reset is held.
   assign ifu_req_ready = hs && (pick_id == GNT_IFU) && !rst;
   assign lsu_req_ready = hs && (pick_id == GNT_LSU) && !rst;

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      ptr_d    = ptr_q;
      wen_d    = wen_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wmask_d  = wmask_q;
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      cmd_d    = 1'b0;
      mwen_d   = 1'b0;
      mren_d   = 1'b0;
      ifu_rv_d = ifu_rv_q;
      lsu_rv_d = lsu_rv_q;
      case (state_q)
         IDLE: begin
            if (hs) begin
               gnt_d = pick_id;
               ptr_d = pick_id;
               if (pick_id == GNT_LSU) begin
                  wen_d   = lsu_wen;
                  addr_d  = lsu_addr;
                  wdata_d = lsu_wdata;
                  wmask_d = lsu_wmask;
               end else begin
                  wen_d   = 1'b0;
                  addr_d  = ifu_addr;
                  wdata_d = '0;
                  wmask_d = '0;
               end
               // Command strobes are registered so they are high exactly in ISSUE.
               cmd_d   = 1'b1;
               mwen_d  = wen_d;
               mren_d  = ~wen_d;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (mem_ready) begin
               rdata_d = wen_q ? '0 : mem_dout;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (cnt_q == CNT_MAX) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
            if (state_d == RESP) begin
               ifu_rv_d = (gnt_q == GNT_IFU);
               lsu_rv_d = (gnt_q == GNT_LSU);
            end
         end
         RESP: begin
            if ((gnt_q == GNT_IFU) ? ifu_resp_ready : lsu_resp_ready) begin
               ifu_rv_d = 1'b0;
               lsu_rv_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         gnt_q    <= GNT_IFU;
         ptr_q    <= GNT_IFU;
         wen_q    <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wmask_q  <= '0;
         cnt_q    <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         cmd_q    <= 1'b0;
         mwen_q   <= 1'b0;
         mren_q   <= 1'b0;
         ifu_rv_q <= 1'b0;
         lsu_rv_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         ptr_q    <= ptr_d;
         wen_q    <= wen_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wmask_q  <= wmask_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         cmd_q    <= cmd_d;
         mwen_q   <= mwen_d;
         mren_q   <= mren_d;
         ifu_rv_q <= ifu_rv_d;
         lsu_rv_q <= lsu_rv_d;
      end
   end

   assign mem_inst_ready = cmd_q;
   assign mem_wen        = mwen_q;
   assign mem_ren        = mren_q;
   assign mem_waddr      = addr_q;
   assign mem_raddr      = addr_q;
   assign mem_din        = wdata_q;
   assign mem_wmask      = wmask_q;

   // Response data is only presented to the requester that owns the transaction.
   assign ifu_resp_valid = ifu_rv_q;
   assign ifu_rdata      = ifu_rv_q ? rdata_q : '0;
   assign ifu_resp_err   = ifu_rv_q & err_q;
   assign lsu_resp_valid = lsu_rv_q;
   assign lsu_rdata      = lsu_rv_q ? rdata_q : '0;
   assign lsu_resp_err   = lsu_rv_q & err_q;

endmodule
`default_nettype wire
